// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared letter types and helpers for the Enigma plugboard, rotor and reflector stages
package enigma_pkg;

  localparam int ASCII_A     = 65;
  localparam int NUM_LETTERS = 26;

  typedef logic [4:0] letter_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } plug_state_t;

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= 8'(ASCII_A)) && (c < 8'(ASCII_A + NUM_LETTERS));
  endfunction

  function automatic letter_idx_t to_idx(input logic [7:0] c);
    return letter_idx_t'(c - 8'(ASCII_A));
  endfunction

  function automatic logic [7:0] to_ascii(input letter_idx_t idx);
    return {3'b000, idx} + 8'(ASCII_A);
  endfunction

endpackage

// File: rtl/enigma_plug_lookup.sv
// rtl/enigma_plug_lookup.sv - combinational 26-way plugboard map read (index in, partner index out)
module enigma_plug_lookup
  import enigma_pkg::*;
(
  input  logic [NUM_LETTERS*5-1:0] map_flat,
  input  logic [4:0]               idx,
  output logic [4:0]               partner
);

  // Out-of-range indices fall back to themselves; callers only use letter results.
  always_comb begin
    partner = idx;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (idx == letter_idx_t'(i)) partner = map_flat[i*5 +: 5];
    end
  end

endmodule

// File: rtl/enigma_plugboard.sv
// rtl/enigma_plugboard.sv - steckered letter-swap stage wrapped around the rotor path
// Optional rotor watchdog and timeout_err port: define ENIGMA_PLUG_TIMEOUT_EN.
module enigma_plugboard
  import enigma_pkg::*;
#(
  parameter int MAX_PAIRS      = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pair_wr,
  input  logic [7:0] pair_a,
  input  logic [7:0] pair_b,
  input  logic       clear,
  input  logic       valid,
  input  logic [7:0] din,
  output logic       rot_valid,
  output logic [7:0] rot_din,
  input  logic       rot_done,
  input  logic [7:0] rot_dout,
  output logic [7:0] dout,
  output logic       done,
  output logic       busy,
  output logic [3:0] pair_cnt,
`ifdef ENIGMA_PLUG_TIMEOUT_EN
  output logic       timeout_err,
`endif
  output logic       cfg_err
);

  plug_state_t               state;
  letter_idx_t               map [NUM_LETTERS];
  logic [NUM_LETTERS*5-1:0]  map_flat;
  letter_idx_t               fwd_partner;
  letter_idx_t               ret_partner;
  letter_idx_t               a_idx;
  letter_idx_t               b_idx;
  logic                      pair_ok;

  always_comb begin
    map_flat = '0;
    for (int i = 0; i < NUM_LETTERS; i++) map_flat[i*5 +: 5] = map[i];
  end

  enigma_plug_lookup u_fwd (
    .map_flat (map_flat),
    .idx      (to_idx(din)),
    .partner  (fwd_partner)
  );

  enigma_plug_lookup u_ret (
    .map_flat (map_flat),
    .idx      (to_idx(rot_dout)),
    .partner  (ret_partner)
  );

  assign a_idx = to_idx(pair_a);
  assign b_idx = to_idx(pair_b);

  // Both letters must still be unplugged so the map stays a pure involution.
  assign pair_ok = is_letter(pair_a) && is_letter(pair_b) && (a_idx != b_idx) &&
                   (map[a_idx] == a_idx) && (map[b_idx] == b_idx) &&
                   (int'(pair_cnt) < MAX_PAIRS);

  assign busy = (state != IDLE);

`ifdef ENIGMA_PLUG_TIMEOUT_EN
  logic [31:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rot_valid <= 1'b0;
      rot_din   <= 8'h00;
      dout      <= 8'h00;
      done      <= 1'b0;
      pair_cnt  <= 4'd0;
      cfg_err   <= 1'b0;
      for (int i = 0; i < NUM_LETTERS; i++) map[i] <= letter_idx_t'(i);
`ifdef ENIGMA_PLUG_TIMEOUT_EN
      timeout_err <= 1'b0;
      wait_cnt    <= 32'd0;
`endif
    end else begin
      rot_valid <= 1'b0;
      done      <= 1'b0;

      if ((state == IDLE) && clear) begin
        for (int i = 0; i < NUM_LETTERS; i++) map[i] <= letter_idx_t'(i);
        pair_cnt <= 4'd0;
        cfg_err  <= 1'b0;
`ifdef ENIGMA_PLUG_TIMEOUT_EN
        timeout_err <= 1'b0;
`endif
      end else if (pair_wr) begin
        if ((state != IDLE) || !pair_ok) begin
          cfg_err <= 1'b1;
        end else begin
          map[a_idx] <= b_idx;
          map[b_idx] <= a_idx;
          pair_cnt   <= pair_cnt + 4'd1;
        end
      end

      case (state)
        IDLE: begin
          if (valid) begin
            if (is_letter(din)) begin
              rot_din   <= to_ascii(fwd_partner);
              rot_valid <= 1'b1;
              state     <= WAIT;
`ifdef ENIGMA_PLUG_TIMEOUT_EN
              wait_cnt  <= 32'd0;
`endif
            end else begin
              dout  <= din;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        WAIT: begin
          if (rot_done) begin
            dout  <= is_letter(rot_dout) ? to_ascii(ret_partner) : rot_dout;
            done  <= 1'b1;
            state <= DONE;
          end
`ifdef ENIGMA_PLUG_TIMEOUT_EN
          else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/enigma_plugboard.md
Name: enigma_plugboard

Overview:
- Plugboard stage that wraps the rotor path of the Enigma datapath.
- Takes ASCII characters from the input interface and applies the steckered letter-pair swap.
- Issues each swapped character to the rotor stage, waits for the rotor's done, then applies the same swap on the return path and presents the result.
- Holds a run-time programmable, symmetric 26-entry swap map with pair-validity checking.

Parameters:
- MAX_PAIRS, 10, maximum number of simultaneously programmed letter pairs (1..13).
- TIMEOUT_CYCLES, 1024, rotor-response watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- pair_wr  in  1  one-cycle strobe: program pair (pair_a, pair_b).
- pair_a  in  8  ASCII letter A..Z.
- pair_b  in  8  ASCII letter A..Z.
- clear  in  1  one-cycle strobe: restore identity map, pair count to 0.
- valid  in  1  input character strobe.
- din  in  8  input ASCII character.
- rot_valid  out  1  one-cycle pulse to the rotor: rot_din is valid.
- rot_din  out  8  forward-swapped character to the rotor.
- rot_done  in  1  rotor result strobe; rot_dout is valid while high.
- rot_dout  in  8  rotor output character.
- dout  out  8  final character; held until the next done.
- done  out  1  one-cycle result pulse.
- busy  out  1  high in any state other than IDLE.
- pair_cnt  out  4  number of programmed pairs.
- cfg_err  out  1  sticky configuration error; cleared by clear or reset.

Behaviour:
- Reset: map is identity; pair_cnt=0; cfg_err=0; dout=0; done=0; rot_valid=0; rot_din=0; state IDLE.
- Reset asserted mid-operation: abort immediately, drop any pending rotor transaction, produce no done.
- Letter test: L is a letter iff 65 <= L <= 90. Map index = L-65, 5 bits.
- Map storage: 26 x 5-bit registers. Entry i holds the partner index. Identity means entry i = i.
- pair_wr accepted only in IDLE. The pair is written (map[a]=b, map[b]=a, pair_cnt+1) only if all of the following hold:
  - both are letters;
  - a != b;
  - both are currently self-mapped;
  - pair_cnt < MAX_PAIRS.
- Any failing condition: map unchanged, cfg_err set.
- pair_wr outside IDLE: ignored, cfg_err set.
- clear: accepted only in IDLE; ignored otherwise. Same cycle as pair_wr: clear wins and pair_wr is dropped.
- FSM states: IDLE, WAIT, DONE.
- IDLE, valid=1 with din a letter:
  - register rot_din = map[din-65]+65 and rot_valid=1 for exactly one cycle;
  - go to WAIT.
- IDLE, valid=1 with din not a letter (bypass):
  - dout=din;
  - go to DONE; the rotor is not invoked.
- WAIT:
  - on rot_done=1, if rot_dout is a letter, dout = map[rot_dout-65]+65; otherwise dout=rot_dout;
  - go to DONE.
- WAIT with rot_done=0: remain in WAIT.
- DONE: done=1 for one cycle, then IDLE.
- Latency: the rotor request is issued one cycle after valid. Bypass done is issued 1 cycle after valid. Rotor-path done is issued 1 cycle after rot_done is sampled.
- valid while busy: ignored, no error. valid in DONE is also ignored.
- valid and pair_wr in the same IDLE cycle: both act. The character uses the pre-write map.
- rot_done outside WAIT: ignored.
- Map symmetry is an invariant: map[map[i]]==i for all i at all times.

Optional Feature:
- Macro: ENIGMA_PLUG_TIMEOUT_EN.
- When defined:
  - a 32-bit counter runs in WAIT;
  - if TIMEOUT_CYCLES elapse without rot_done: go to IDLE, no done, and set sticky output timeout_err (1 bit, extra port);
  - timeout_err is cleared by clear or reset.
- When undefined: WAIT has no time limit, and the timeout_err port and counter do not exist.

Decomposition:
- Package enigma_pkg:
  - ASCII_A=65, NUM_LETTERS=26;
  - letter_idx_t (5-bit);
  - plug state enum (IDLE/WAIT/DONE);
  - is_letter function;
  - shared with the rotor and reflector stages.
- Sub-module enigma_plug_lookup: combinational 26-way map read (index in, partner index out). Instantiated twice: forward and return paths.

Test Plan:
- Reset, then valid din=0x41 ('A') with no pairs; rotor model returns 0x51 -> rot_din=0x41, dout=0x51, done 1 cycle after rot_done.
- Program (A,Z),(Q,E); din='A'; rotor returns 'Q' -> rot_din=0x5A, dout=0x45, pair_cnt=2, cfg_err=0.
- din=0x20 (space) -> rot_valid never pulses; dout=0x20 and done one cycle after valid.
- Error cases each set cfg_err with the map unchanged:
  - pair_wr (A,A);
  - pair (A,B) after (A,Z);
  - an 11th pair with MAX_PAIRS=10;
  - pair_wr while busy.
  - clear then restores identity, pair_cnt=0, cfg_err=0.
- Assert reset while in WAIT, then release, then drive rot_done -> no done; identity map; next character is processed normally.
- With ENIGMA_PLUG_TIMEOUT_EN and TIMEOUT_CYCLES=8: rotor never responds -> IDLE after 8 WAIT cycles, timeout_err=1, done stays 0.
